// File: rtl/alu_long_seq_pkg.sv
// Shared types and constants for the 64-bit two-pass add/subtract sequencer.
package alu_long_seq_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;

  typedef enum logic [1:0] {
    OP_ADD64 = 2'b00,
    OP_SUB64 = 2'b01,
    OP_ADC64 = 2'b10,
    OP_SBC64 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
  } req_t;

endpackage

// File: rtl/alu_long_seq_alu.sv
// 32-bit execute-stage ALU. status_bits = {N,Z,C,V}; on subtract C is a borrow (1 = borrow).
module alu_long_seq_alu
  import alu_long_seq_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        carry_in,
  input  logic [3:0]  exe_cmd,
  output logic [3:0]  status_bits,
  output logic [31:0] result
);

  logic [32:0] sum;
  logic        c, v;

  always_comb begin
    sum = 33'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (exe_cmd)
      EXE_MOV: sum = {1'b0, in2};
      EXE_ADD, EXE_ADC: begin
        sum = {1'b0, in1} + {1'b0, in2} + {32'd0, (exe_cmd == EXE_ADC) & carry_in};
        c   = sum[32];
        v   = (in1[31] == in2[31]) & (sum[31] != in1[31]);
      end
      EXE_SUB, EXE_SBC: begin
        // a - b - borrow_in as a + ~b + carry, with carry 1 for plain SUB
        sum = {1'b0, in1} + {1'b0, ~in2} + {32'd0, (exe_cmd == EXE_SUB) | carry_in};
        c   = ~sum[32];
        v   = (in1[31] != in2[31]) & (sum[31] != in1[31]);
      end
      default: sum = 33'd0;
    endcase
  end

  assign result      = sum[31:0];
  assign status_bits = {sum[31], sum[31:0] == 32'd0, c, v};

endmodule

// File: rtl/alu_long_seq.sv
// 64-bit add/subtract sequenced over one 32-bit ALU: low word, then high word with chained carry.
module alu_long_seq
  import alu_long_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        cin_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [63:0] result_o,
  output logic [3:0]  flags_o
);

  state_e      state;
  req_t        req;
  logic [31:0] res_lo;
  logic        c_lo, z_lo;

  logic [31:0] alu_in1, alu_in2, alu_res;
  logic        alu_cin;
  logic [3:0]  alu_cmd, alu_st;
  logic        is_sub;

  assign is_sub = (req.op == OP_SUB64) || (req.op == OP_SBC64);

  always_comb begin
    alu_in1 = 32'd0;
    alu_in2 = 32'd0;
    alu_cin = 1'b0;
    alu_cmd = EXE_NOP;
    case (state)
      ST_LO: begin
        alu_in1 = req.a[31:0];
        alu_in2 = req.b[31:0];
        case (req.op)
          OP_ADD64: alu_cmd = EXE_ADD;
          OP_SUB64: alu_cmd = EXE_SUB;
          OP_ADC64: begin alu_cmd = EXE_ADC; alu_cin = req.cin; end
          default:  begin alu_cmd = EXE_SBC; alu_cin = req.cin; end
        endcase
      end
      ST_HI: begin
        alu_in1 = req.a[63:32];
        alu_in2 = req.b[63:32];
        alu_cmd = is_sub ? EXE_SBC : EXE_ADC;
        // low-pass subtract C is a borrow; SBC wants carry = not-borrow
        alu_cin = is_sub ? ~c_lo : c_lo;
      end
      default: ;
    endcase
  end

  alu_long_seq_alu u_alu (
    .in1         (alu_in1),
    .in2         (alu_in2),
    .carry_in    (alu_cin),
    .exe_cmd     (alu_cmd),
    .status_bits (alu_st),
    .result      (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req      <= '0;
      res_lo   <= 32'd0;
      c_lo     <= 1'b0;
      z_lo     <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      result_o <= 64'd0;
      flags_o  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          req     <= '{op: op_e'(op_i), a: a_i, b: b_i, cin: cin_i};
          ready_o <= 1'b0;
          state   <= ST_LO;
        end
        ST_LO: begin
          res_lo <= alu_res;
          c_lo   <= alu_st[1];
          z_lo   <= alu_st[2];
          state  <= ST_HI;
        end
        ST_HI: begin
          result_o <= {alu_res, res_lo};
          flags_o  <= {alu_st[3], z_lo & alu_st[2], alu_st[1], alu_st[0]};
          done_o   <= 1'b1;
          state    <= ST_DONE;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_long_seq.sv
// Self-checking bench for alu_long_seq: directed corner cases plus randomized ops vs a 64-bit arithmetic model.
module tb_alu_long_seq;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, start_i, cin_i;
  logic [1:0]  op_i;
  logic [63:0] a_i, b_i;
  logic        ready_o, done_o;
  logic [63:0] result_o;
  logic [3:0]  flags_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  alu_long_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: whole 64-bit arithmetic; C is carry-out for add, borrow for subtract.
  task automatic model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, output logic [63:0] r, output logic [3:0] f);
    logic [64:0] s;
    logic        v, sub;
    sub = op[0];
    case (op)
      ADD:     s = {1'b0, a} + {1'b0, b};
      ADC:     s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      SUB:     s = {1'b0, a} - {1'b0, b};
      default: s = {1'b0, a} - {1'b0, b} - {64'd0, ~cin};
    endcase
    r = s[63:0];
    if (sub) v = (a[63] != b[63]) && (r[63] != a[63]);
    else     v = (a[63] == b[63]) && (r[63] != a[63]);
    f = {r[63], r == 64'd0, s[64], v};
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h0000_0000_FFFF_FFFF;
      5:       return {32'd0, $urandom_range(0, 3)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One full transaction; optionally pokes start with new operands while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input bit poke);
    logic [63:0] er;
    logic [3:0]  ef;
    int          d0;
    model(op, a, b, cin, er, ef);
    chk({tag, ".rdy_in"}, {63'd0, ready_o}, 64'd1);
    d0 = done_cnt;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; cin_i = cin;
    step();                                 // LO
    start_i = poke;
    a_i = rand64(); b_i = rand64(); op_i = 2'($urandom); cin_i = 1'($urandom);
    chk({tag, ".rdy_lo"}, {63'd0, ready_o}, 64'd0);
    step();                                 // HI
    start_i = 1'b0;
    chk({tag, ".rdy_hi"}, {63'd0, ready_o}, 64'd0);
    chk({tag, ".done_hi"}, {63'd0, done_o}, 64'd0);
    step();                                 // DONE
    chk({tag, ".done"}, {63'd0, done_o}, 64'd1);
    chk({tag, ".rdy_dn"}, {63'd0, ready_o}, 64'd0);
    chk({tag, ".res"}, result_o, er);
    chk({tag, ".flg"}, {60'd0, flags_o}, {60'd0, ef});
    step();                                 // back in IDLE
    chk({tag, ".done_off"}, {63'd0, done_o}, 64'd0);
    chk({tag, ".rdy_back"}, {63'd0, ready_o}, 64'd1);
    chk({tag, ".res_hold"}, result_o, er);
    chk({tag, ".npulse"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start_i = 1'b0; op_i = 2'd0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (3) step();
    chk("rst.rdy", {63'd0, ready_o}, 64'd1);
    chk("rst.done", {63'd0, done_o}, 64'd0);
    chk("rst.res", result_o, 64'd0);
    chk("rst.flg", {60'd0, flags_o}, 64'd0);
    rst_n = 1'b1;
    step();

    run_op("add_cy", ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op("sub_bw", SUB, 64'h0000_0001_0000_0000, 64'd1, 1'b0, 1'b0);
    run_op("add_ov", ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op("sub_z", SUB, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    run_op("sub_nz", SUB, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    run_op("poke", ADD, 64'h0000_0003_0000_0005, 64'h0000_0004_0000_0006, 1'b0, 1'b1);

    // reset during HI discards the operation
    d0 = done_cnt;
    start_i = 1'b1; op_i = ADD; a_i = 64'h1111_2222_3333_4444; b_i = 64'h1; cin_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rhi.rdy", {63'd0, ready_o}, 64'd1);
    chk("rhi.done", {63'd0, done_o}, 64'd0);
    chk("rhi.res", result_o, 64'd0);
    chk("rhi.flg", {60'd0, flags_o}, 64'd0);
    step();
    chk("rhi.nodone", 64'(done_cnt - d0), 64'd0);
    run_op("adc_one", ADC, 64'd0, 64'd0, 1'b1, 1'b0);

    // start during reset is dropped
    d0 = done_cnt;
    rst_n = 1'b0; start_i = 1'b1; op_i = ADD; a_i = 64'd5; b_i = 64'd6;
    step();
    rst_n = 1'b1; start_i = 1'b0;
    chk("rst_st.rdy", {63'd0, ready_o}, 64'd1);
    repeat (4) step();
    chk("rst_st.nodone", 64'(done_cnt - d0), 64'd0);
    chk("rst_st.res", result_o, 64'd0);

    for (int i = 0; i < 60; i++)
      run_op($sformatf("rnd%0d", i), 2'($urandom), rand64(), rand64(), 1'($urandom),
             1'($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_long_seq.md
# alu_long_seq

Two-pass sequencer that performs 64-bit add/subtract on the 32-bit execute-stage ALU by splitting each operation into a low-word cycle and a high-word cycle, with carry chained between them. It sits beside the execute stage and owns one ALU instance. It accepts a request through a start/ready handshake and returns a registered 64-bit result plus NZCV flags with a one-cycle done pulse.

## Interface
- No parameters. Widths are fixed: 32-bit ALU, 64-bit operands.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  request strobe. Accepted only when ready_o=1.
- op_i  in  2  00 ADD64, 01 SUB64, 10 ADC64, 11 SBC64.
- a_i  in  64  first operand.
- b_i  in  64  second operand.
- cin_i  in  1  carry input, used by ADC64/SBC64 only (ARM convention: 1 = no borrow).
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse when result_o/flags_o are valid.
- result_o  out  64  registered result; held until the next accepted start.
- flags_o  out  4  {N,Z,C,V}; held alongside result_o.

## Operation
- States: IDLE → LO → HI → DONE → IDLE.
- IDLE: on start_i, latch a_i, b_i, op_i and cin_i, then go to LO. Without start_i, stay in IDLE.
- LO: drive the ALU with the low words.
  - ADD64: cmd 0010, carry_in 0.
  - SUB64: cmd 0100, carry_in 0.
  - ADC64: cmd 0011, carry_in cin.
  - SBC64: cmd 0101, carry_in cin.
  - Latch res_lo, c_lo = ALU C and z_lo = ALU Z.
- HI: drive the ALU with the high words.
  - ADD64/ADC64: cmd 0011, carry_in = c_lo.
  - SUB64/SBC64: cmd 0101, carry_in = ~c_lo. The ALU's subtract C is a borrow (1 = borrow), so it is inverted to the SBC carry convention.
  - Latch result_o = {res_hi, res_lo}.
  - Latch flags_o: N = ALU N, Z = z_lo & ALU Z, C = ALU C (raw, borrow sense for subtract), V = ALU V.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- start_i outside IDLE is ignored; no queueing and no side effects.
- Operand changes after acceptance have no effect.
- In IDLE, the ALU inputs are driven to 0 with cmd 0000 (inactive).

## Timing
- Reset values: ready_o=1, done_o=0, result_o=0, flags_o=0, state=IDLE. Internal c_lo, z_lo and res_lo are cleared.
- Start sampled at edge T. LO runs during T+1, HI during T+2, done_o=1 during T+3, ready_o=1 again at T+4.
- result_o/flags_o update at the edge ending HI. They are stable from the done cycle until the edge that ends the next HI.
- Throughput is one operation per 4 cycles.
- If rst_n=0 in any state, the next edge forces the reset values. An in-flight operation is discarded with no done pulse.
- start_i and rst_n=0 in the same cycle: reset wins and the request is dropped.
- Wrap-around: results are modulo 2^64. Carry/borrow out of bit 63 appears only in flags_o.C.

## Structure
- Shared package holds:
  - ALU command constants: EXE_MOV=0001, EXE_ADD=0010, EXE_ADC=0011, EXE_SUB=0100, EXE_SBC=0101.
  - op_i encodings (OP_ADD64, OP_SUB64, OP_ADC64, OP_SBC64).
  - 2-bit state encoding.
- One sub-module: the existing ALU (in1, in2, carry_in, exe_cmd, status_bits, result), instantiated once.
- Command selection is a small combinational mux on (state, op).

## Test plan
- ADD64 0x00000000_FFFFFFFF + 0x00000000_00000001 → result 0x00000001_00000000, flags 0000, done_o at T+3, ready_o low T+1..T+3.
- SUB64 0x00000001_00000000 − 0x00000000_00000001 → result 0x00000000_FFFFFFFF, flags N0 Z0 C0 V0. Checks borrow inversion into the high pass.
- ADD64 0x7FFFFFFF_FFFFFFFF + 1 → result 0x80000000_00000000, flags N1 Z0 C0 V1.
- SUB64 0x12345678_9ABCDEF0 − the same value → result 0, flags Z1 (z_lo & z_hi). Separately, 0x00000001_00000000 − 0x00000001_00000001 → Z0, N1.
- start_i pulsed during LO with different operands → ignored; the first result is unchanged and there is exactly one done pulse.
- rst_n low during HI → next cycle ready_o=1, result_o=0, flags_o=0, no done pulse. A following ADC64 with cin_i=1 of 0 + 0 → result 1.
